// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output stage and collision reporting.
module dual_port_ram_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // port A
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     data_a,
    output logic [DATA_W-1:0]     q_a,
    output logic                  valid_a,
    // port B
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     data_b,
    output logic [DATA_W-1:0]     q_b,
    output logic                  valid_b,
    // collision reporting
    output logic                  coll,
    output logic [CNT_W-1:0]      coll_cnt
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // storage array, intentionally never reset
    logic [DATA_W-1:0] mem [DEPTH];

    // access decode
    logic              wr_a;
    logic              wr_b;
    logic              same_addr;
    logic              both_wr;
    logic              coll_c;
    logic              mem_we_a;
    logic              mem_we_b;

    // words read at the edge and merged write words
    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [DATA_W-1:0] wdat_a;
    logic [DATA_W-1:0] wdat_b;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;

    // first output stage
    logic [DATA_W-1:0] q1_a_d;
    logic [DATA_W-1:0] q1_a_q;
    logic [DATA_W-1:0] q1_b_d;
    logic [DATA_W-1:0] q1_b_q;
    logic              v1_a_d;
    logic              v1_a_q;
    logic              v1_b_d;
    logic              v1_b_q;

    // collision pulse and saturating count
    logic              coll_d;
    logic              coll_q;
    logic [CNT_W-1:0]  coll_cnt_d;
    logic [CNT_W-1:0]  coll_cnt_q;

    // Decode port activity and detect same-address collisions.
    always_comb begin
        wr_a      = en_a & we_a;
        wr_b      = en_b & we_b;
        same_addr = (addr_a == addr_b);
        both_wr   = wr_a & wr_b & same_addr;
        coll_c    = en_a & en_b & same_addr & (we_a | we_b);
        mem_we_a  = wr_a & rst_n;
        mem_we_b  = wr_b & rst_n;
    end

    // Byte-lane merge; on a double write B lanes go in first so A wins overlaps.
    always_comb begin
        old_a  = mem[addr_a];
        old_b  = mem[addr_b];
        wdat_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_b[i]) begin
                wdat_b[8*i +: 8] = data_b[8*i +: 8];
            end
        end
        wdat_a = both_wr ? wdat_b : old_a;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be_a[i]) begin
                wdat_a[8*i +: 8] = data_a[8*i +: 8];
            end
        end
        if (both_wr) begin
            wdat_b = wdat_a;
        end
    end

    // Per-port result: old word, or merged word for a write-first writer.
    // A port reading a word the other port writes always sees the old word.
    always_comb begin
        res_a = old_a;
        res_b = old_b;
        if (RDW_MODE != 0) begin
            if (wr_a) begin
                res_a = wdat_a;
            end
            if (wr_b) begin
                res_b = wdat_b;
            end
        end
    end

    // Array write; both ports carry the same merged word on a double write.
    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem[addr_a] <= wdat_a;
        end
        if (mem_we_b) begin
            mem[addr_b] <= wdat_b;
        end
    end

    // Next-state for first output stage and collision reporting.
    always_comb begin
        q1_a_d     = q1_a_q;
        q1_b_d     = q1_b_q;
        v1_a_d     = en_a;
        v1_b_d     = en_b;
        coll_d     = coll_c;
        coll_cnt_d = coll_cnt_q;
        if (en_a) begin
            q1_a_d = res_a;
        end
        if (en_b) begin
            q1_b_d = res_b;
        end
        if (coll_c && (coll_cnt_q != {CNT_W{1'b1}})) begin
            coll_cnt_d = coll_cnt_q + CNT_W'(1);
        end
    end

    // First output stage and collision registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a_q     <= '0;
            q1_b_q     <= '0;
            v1_a_q     <= 1'b0;
            v1_b_q     <= 1'b0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            q1_a_q     <= q1_a_d;
            q1_b_q     <= q1_b_d;
            v1_a_q     <= v1_a_d;
            v1_b_q     <= v1_b_d;
            coll_q     <= coll_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll     = coll_q;
    assign coll_cnt = coll_cnt_q;

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] q2_a_d;
        logic [DATA_W-1:0] q2_a_q;
        logic [DATA_W-1:0] q2_b_d;
        logic [DATA_W-1:0] q2_b_q;
        logic              v2_a_d;
        logic              v2_a_q;
        logic              v2_b_d;
        logic              v2_b_q;

        // Second stage simply delays the first; holding propagates naturally.
        always_comb begin
            q2_a_d = q1_a_q;
            q2_b_d = q1_b_q;
            v2_a_d = v1_a_q;
            v2_b_d = v1_b_q;
        end

        // Extra output register stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2_a_q <= '0;
                q2_b_q <= '0;
                v2_a_q <= 1'b0;
                v2_b_q <= 1'b0;
            end else begin
                q2_a_q <= q2_a_d;
                q2_b_q <= q2_b_d;
                v2_a_q <= v2_a_d;
                v2_b_q <= v2_b_d;
            end
        end

        assign q_a     = q2_a_q;
        assign q_b     = q2_b_q;
        assign valid_a = v2_a_q;
        assign valid_b = v2_b_q;
    end else begin : g_no_out_reg
        assign q_a     = q1_a_q;
        assign q_b     = q1_b_q;
        assign valid_a = v1_a_q;
        assign valid_b = v1_b_q;
    end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: two configurations driven by shared stimulus,
// each compared against a word/lane level reference model.
module tb_dual_port_ram_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    // config X: 8-bit, 64 deep, read-first, latency 1, 16-bit counter
    logic [7:0]  xq_a, xq_b;
    logic        xv_a, xv_b, xcoll;
    logic [15:0] xcnt;
    // config Y: 32-bit, 16 deep, write-first, latency 2, 2-bit counter
    logic [31:0] yq_a, yq_b;
    logic        yv_a, yv_b, ycoll;
    logic [1:0]  ycnt;

    always #5 clk = ~clk;

    dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .CNT_W(16)) u_dut_x (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a[0:0]), .addr_a(addr_a), .data_a(data_a[7:0]),
        .q_a(xq_a), .valid_a(xv_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b[0:0]), .addr_b(addr_b), .data_b(data_b[7:0]),
        .q_b(xq_b), .valid_b(xv_b),
        .coll(xcoll), .coll_cnt(xcnt)
    );

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .CNT_W(2)) u_dut_y (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a[3:0]), .data_a(data_a),
        .q_a(yq_a), .valid_a(yv_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b[3:0]), .data_b(data_b),
        .q_b(yq_b), .valid_b(yv_b),
        .coll(ycoll), .coll_cnt(ycnt)
    );

    // reference model state, index [cfg][port]
    logic [31:0] mm    [2][64];
    logic [3:0]  mk    [2][64];
    logic [31:0] s1q   [2][2];
    bit          s1k   [2][2];
    bit          s1v   [2][2];
    logic [31:0] exp_q [2][2];
    bit          exp_k [2][2];
    bit          exp_v [2][2];
    bit          ecoll [2];
    int unsigned ecnt  [2];

    int checks;
    int failures;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                s1q[d][p]   = '0;
                s1k[d][p]   = 1'b1;
                s1v[d][p]   = 1'b0;
                exp_q[d][p] = '0;
                exp_k[d][p] = 1'b1;
                exp_v[d][p] = 1'b0;
            end
            ecoll[d] = 1'b0;
            ecnt[d]  = 0;
        end
    endtask

    // One accepting clock edge for configuration d.
    task automatic model_edge(input int d);
        int          nb;
        int unsigned cmax;
        bit          rdw;
        bit          lat2;
        logic [3:0]  full;
        logic [5:0]  am;
        logic [5:0]  a    [2];
        logic [31:0] oldw [2];
        logic [3:0]  oldk [2];
        logic [31:0] res  [2];
        bit          rk   [2];
        bit          en   [2];
        bit          wr   [2];
        nb   = (d == 0) ? 1 : 4;
        cmax = (d == 0) ? 65535 : 3;
        rdw  = (d == 1);
        lat2 = (d == 1);
        full = (d == 0) ? 4'h1 : 4'hF;
        am   = (d == 0) ? 6'h3F : 6'h0F;
        a[0] = addr_a & am;
        a[1] = addr_b & am;
        en[0] = en_a;
        en[1] = en_b;
        wr[0] = en_a && we_a;
        wr[1] = en_b && we_b;
        for (int p = 0; p < 2; p++) begin
            oldw[p] = mm[d][a[p]];
            oldk[p] = mk[d][a[p]];
        end
        // B first, then A: A's enabled lanes win on a shared word
        if (wr[1]) begin
            for (int i = 0; i < nb; i++) begin
                if (be_b[i]) begin
                    mm[d][a[1]][8*i +: 8] = data_b[8*i +: 8];
                    mk[d][a[1]][i] = 1'b1;
                end
            end
        end
        if (wr[0]) begin
            for (int i = 0; i < nb; i++) begin
                if (be_a[i]) begin
                    mm[d][a[0]][8*i +: 8] = data_a[8*i +: 8];
                    mk[d][a[0]][i] = 1'b1;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (wr[p] && rdw) begin
                res[p] = mm[d][a[p]];
                rk[p]  = (mk[d][a[p]] & full) == full;
            end else begin
                res[p] = oldw[p];
                rk[p]  = (oldk[p] & full) == full;
            end
            if (lat2) begin
                exp_q[d][p] = s1q[d][p];
                exp_k[d][p] = s1k[d][p];
                exp_v[d][p] = s1v[d][p];
            end
            if (en[p]) begin
                s1q[d][p] = res[p];
                s1k[d][p] = rk[p];
            end
            s1v[d][p] = en[p];
            if (!lat2) begin
                exp_q[d][p] = s1q[d][p];
                exp_k[d][p] = s1k[d][p];
                exp_v[d][p] = s1v[d][p];
            end
        end
        ecoll[d] = en[0] && en[1] && (a[0] == a[1]) && (we_a || we_b);
        if (ecoll[d] && ecnt[d] < cmax) ecnt[d]++;
    endtask

    task automatic check_all();
        check_val("x_valid_a", 32'(xv_a), 32'(exp_v[0][0]));
        check_val("x_valid_b", 32'(xv_b), 32'(exp_v[0][1]));
        if (exp_k[0][0]) check_val("x_q_a", {24'h0, xq_a}, exp_q[0][0]);
        if (exp_k[0][1]) check_val("x_q_b", {24'h0, xq_b}, exp_q[0][1]);
        check_val("x_coll", 32'(xcoll), 32'(ecoll[0]));
        check_val("x_coll_cnt", {16'h0, xcnt}, ecnt[0]);
        check_val("y_valid_a", 32'(yv_a), 32'(exp_v[1][0]));
        check_val("y_valid_b", 32'(yv_b), 32'(exp_v[1][1]));
        if (exp_k[1][0]) check_val("y_q_a", yq_a, exp_q[1][0]);
        if (exp_k[1][1]) check_val("y_q_b", yq_b, exp_q[1][1]);
        check_val("y_coll", 32'(ycoll), 32'(ecoll[1]));
        check_val("y_coll_cnt", {30'h0, ycnt}, ecnt[1]);
    endtask

    task automatic drive(input bit ea, input bit wa, input logic [5:0] aa, input logic [31:0] da,
                         input logic [3:0] ba, input bit eb, input bit wb, input logic [5:0] ab,
                         input logic [31:0] db, input logic [3:0] bb);
        en_a = ea; we_a = wa; addr_a = aa; data_a = da; be_a = ba;
        en_b = eb; we_b = wb; addr_b = ab; data_b = db; be_b = bb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    endtask

    // Advance one edge, update model, check outputs, return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] ra;
        logic [5:0] rb;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                mm[d][i] = '0;
                mk[d][i] = '0;
            end
        end
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // fill every word through port A
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b1, 6'(i), $urandom, 4'hF, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
            step();
        end

        // write A then read B at address 5
        drive(1'b1, 1'b1, 6'd5, 32'h3C, 4'hF, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        drive(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
        step();
        check_val("plan_rd_q_b", {24'h0, xq_b}, 32'h3C);
        check_val("plan_rd_valid_b", 32'(xv_b), 32'd1);
        idle();
        step();
        check_val("plan_idle_valid_b", 32'(xv_b), 32'd0);
        check_val("plan_idle_q_b", {24'h0, xq_b}, 32'h3C);

        // byte-lane write and read-during-write behaviour at address 9
        drive(1'b1, 1'b1, 6'd9, 32'h11223344, 4'hF, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        drive(1'b1, 1'b1, 6'd9, 32'hAABBCCDD, 4'h5, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        check_val("plan_rdw0_q_a", {24'h0, xq_a}, 32'h44);
        idle();
        step();
        check_val("plan_rdw1_q_a", yq_a, 32'h11BB33DD);
        drive(1'b1, 1'b0, 6'd9, 32'h0, 4'h0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        idle();
        step();
        check_val("plan_lane_rd_q_a", yq_a, 32'h11BB33DD);
        check_val("plan_lane_rd_valid_a", 32'(yv_a), 32'd1);

        // collisions at address 12
        drive(1'b1, 1'b1, 6'd12, 32'h55, 4'h1, 1'b1, 1'b1, 6'd12, 32'hAA, 4'h1);
        step();
        check_val("plan_coll_pulse", 32'(xcoll), 32'd1);
        check_val("plan_coll_cnt1", {16'h0, xcnt}, 32'd1);
        drive(1'b1, 1'b0, 6'd12, 32'h0, 4'h0, 1'b1, 1'b1, 6'd12, 32'h77, 4'h1);
        step();
        check_val("plan_coll_rd_old", {24'h0, xq_a}, 32'h55);
        check_val("plan_coll_cnt2", {16'h0, xcnt}, 32'd2);
        idle();
        step();
        check_val("plan_coll_drop", 32'(xcoll), 32'd0);

        // counter saturation, then a same-address double read
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 6'd3, $urandom, 4'($urandom), 1'b1, 1'b1, 6'd3, $urandom, 4'($urandom));
            step();
        end
        check_val("plan_cnt_sat", {30'h0, ycnt}, 32'd3);
        check_val("plan_cnt_x7", {16'h0, xcnt}, 32'd7);
        drive(1'b1, 1'b0, 6'd20, 32'h0, 4'h0, 1'b1, 1'b0, 6'd20, 32'h0, 4'h0);
        step();
        check_val("plan_rd_rd_no_coll", 32'(xcoll), 32'd0);

        // reset in the middle of a read at the top address
        drive(1'b1, 1'b1, 6'd63, 32'hF0, 4'hF, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        drive(1'b1, 1'b0, 6'd63, 32'h0, 4'h0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check_val("plan_rst_y_valid_a", 32'(yv_a), 32'd0);
        check_val("plan_rst_x_cnt", {16'h0, xcnt}, 32'd0);
        drive(1'b1, 1'b1, 6'd63, 32'h0F, 4'hF, 1'b1, 1'b1, 6'd63, 32'h0F, 4'hF);
        @(negedge clk);
        step();
        step();
        idle();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 6'd63, 32'h0, 4'h0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        step();
        check_val("plan_rst_keep_x", {24'h0, xq_a}, 32'hF0);
        idle();
        step();
        check_val("plan_rst_keep_y", yq_a, 32'hF0);

        // random traffic, biased toward shared and boundary addresses
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = 6'd0;
                1:       ra = 6'd63;
                default: ra = 6'($urandom_range(0, 63));
            endcase
            rb = ($urandom_range(0, 2) == 0) ? ra : 6'($urandom_range(0, 63));
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rb, $urandom, 4'($urandom));
            step();
        end
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised true dual-port synchronous RAM and the next generation of the team's 64x8 dual-port RAM.
- Two independent read/write ports share one clock.
- Adds per-port enables, byte-lane write enables, a selectable same-port read-during-write mode, an optional output pipeline stage, read-valid strobes, and same-address collision detection and counting.
- Used as a shared buffer between two datapath agents.

Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8. Byte lanes NB = DATA_W/8.
- ADDR_W, 6: address width. Depth is 2**ADDR_W words.
- RDW_MODE, 0: same-port read-during-write. 0 = read-first (q returns old word); 1 = write-first (q returns merged new word).
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, latency 2.
- CNT_W, 16: width of the collision counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- en_a, input, 1: port A access enable.
- we_a, input, 1: port A write (1) / read (0); ignored when en_a=0.
- be_a, input, NB: port A byte-lane write enables.
- addr_a, input, ADDR_W: port A address.
- data_a, input, DATA_W: port A write data.
- q_a, output, DATA_W: port A read data.
- valid_a, output, 1: q_a carries the result of an access.
- en_b, we_b, be_b, addr_b, data_b, q_b, valid_b: port B, identical to port A.
- coll, output, 1: collision pulse.
- coll_cnt, output, CNT_W: saturating collision count.

Behaviour:
- Reset and memory:
  - Memory array is never reset.
  - rst_n low asynchronously clears q_a, q_b, valid_a, valid_b, coll, coll_cnt and all pipeline registers to 0.
  - While rst_n is low no write occurs and no access is captured.
  - Reset mid-operation discards in-flight reads; memory contents written before reset are retained.
- Access: one access per port per cycle when en_x=1, sampled on the rising edge of clk.
- Write (en_x=1, we_x=1): lane i of mem[addr_x] takes data_x[8i+7:8i] when be_x[i]=1; other lanes are unchanged. be_x=0 is a legal no-op write that still produces a q/valid result.
- Read and write both return data; q_x and valid_x update after the pipeline latency.
  - Read (we_x=0): q_x = mem[addr_x] as sampled at the edge.
  - Write, RDW_MODE=0: q_x = pre-write word.
  - Write, RDW_MODE=1: q_x = post-merge word.
- Latency:
  - OUT_REG=0: result visible one cycle after the accepting edge.
  - OUT_REG=1: result visible two cycles after; fully pipelined, one access per cycle.
  - valid_x follows en_x delayed by the same latency.
- Idle port: when en_x=0, q_x holds its last value and valid_x=0 at the corresponding output cycle.
- Collision definition: en_a=1, en_b=1, addr_a==addr_b, and we_a|we_b.
  - Both writing: per lane, A wins where be_a[i]=1; B's lane is written only where be_a[i]=0 and be_b[i]=1.
  - One port writes, the other reads: the reading port returns the pre-write word regardless of RDW_MODE.
  - Both reading the same address is not a collision.
- Collision reporting:
  - coll is registered and asserted for exactly one cycle, one cycle after the colliding edge, independent of OUT_REG.
  - coll_cnt increments on the same edge coll rises and saturates at all-ones; it does not wrap.
- Addressing: all 2**ADDR_W addresses are valid. Address 0 and address 2**ADDR_W-1 behave identically to any other address; there is no wrap logic.

Test Plan:
- Default params: write A addr 5 = 0x3C, next cycle read B addr 5 -> q_b=0x3C, valid_b=1 one cycle after the read edge; valid_b=0 on the following idle cycle with q_b held at 0x3C.
- DATA_W=32, mem[9]=0x11223344: port A writes addr 9 data 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD. Same-port write with RDW_MODE=0 returns 0x11223344; with RDW_MODE=1 returns 0x11BB33DD.
- Simultaneous write, addr 12, default params: A=0x55 be=1, B=0xAA be=1 -> mem[12]=0x55, coll=1 for one cycle, coll_cnt=1. A reads addr 12 while B writes 0x77 -> q_a = old value 0x55, coll_cnt=2.
- OUT_REG=1, back-to-back port A reads of addrs 0,1,2 (preloaded 0x10,0x20,0x30) -> q_a=0x10,0x20,0x30 on cycles 2,3,4 after the first edge, with valid_a high on all three.
- CNT_W=2: drive 5 consecutive collisions -> coll_cnt reads 1,2,3,3,3. Both ports reading the same address -> coll stays 0.
- Write addr 63=0xF0. Issue a read, then assert rst_n low mid-pipeline (OUT_REG=1) -> q, valid, coll and coll_cnt go to 0 immediately. After release, a read of addr 63 returns 0xF0.
